// File: rtl/word_seq_adder_if.sv
// word_seq_adder operand/result handshake bundle.
// master = producer/consumer side, slave = controller.
interface word_seq_adder_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/word_seq_adder.sv
// Byte-serial word adder/subtractor: one 8-bit slice,
// LSB byte first, carry chained through a register.
module word_seq_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  word_seq_adder_if.slave       bus
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;
  logic [NBYTES-1:0][7:0] sum_q;
  logic [NBYTES-1:0][7:0] sum_nx;
  logic                   sub_q;
  logic                   carry;
  logic [IW-1:0]          idx;
  logic                   cout_q;
  logic                   ovf_q;
  logic                   zero_q;
  logic                   oval_q;

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [7:0] s;
  logic       c;
  logic       last;

  // Slice inputs for the current byte and the word with it merged in.
  always_comb begin
    a_byte      = a_q[idx];
    b_byte      = b_q[idx] ^ {8{sub_q}};
    {c, s}      = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
    sum_nx      = sum_q;
    sum_nx[idx] = s;
    last        = (idx == IW'(NBYTES - 1));
  end

  // Control FSM, byte sequencing and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      oval_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sub_q <= bus.sub;
            carry <= bus.cin ^ bus.sub;
            idx   <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q <= sum_nx;
          carry <= c;
          if (last) begin
            cout_q <= c;
            ovf_q  <= (a_byte[7] == b_byte[7]) &&
                      (s[7] != a_byte[7]);
            zero_q <= (sum_nx == '0);
            oval_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            oval_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = oval_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_word_seq_adder.sv
// Bench for word_seq_adder: directed and random operations
// against an arithmetic reference model, NBYTES = 4 and 1.
module tb_word_seq_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  word_seq_adder_if #(.NBYTES(4)) b4 ();
  word_seq_adder_if #(.NBYTES(1)) b1 ();

  word_seq_adder #(.NBYTES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  word_seq_adder #(.NBYTES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  task automatic chk(input string tag,
                     input longint unsigned obs,
                     input longint unsigned exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level arithmetic: a +/- b with carry/borrow-in, width w.
  function automatic void model(input int w,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                input logic sub,
                                input logic cin,
                                output logic [31:0] s,
                                output logic co,
                                output logic ov,
                                output logic z);
    longint unsigned mask, bb, t;
    logic as, bs, rs;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? (~{32'd0, b}) & mask : {32'd0, b};
    t    = {32'd0, a} + bb + (sub ? {63'd0, !cin} : {63'd0, cin});
    s    = 32'(t & mask);
    co   = t[w];
    as   = a[w-1];
    bs   = b[w-1];
    rs   = s[w-1];
    ov   = sub ? (as != bs && rs != as) : (as == bs && rs != as);
    z    = (s == 32'd0);
  endfunction

  task automatic do_op(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic sub,
                       input logic cin,
                       input int bp);
    logic [31:0] es;
    logic eco, eov, ez;
    int lat;
    model(32, a, b, sub, cin, es, eco, eov, ez);
    @(negedge clk);
    chk("in_ready_idle", b4.in_ready, 1);
    b4.a = a;
    b4.b = b;
    b4.sub = sub;
    b4.cin = cin;
    b4.in_valid = 1'b1;
    b4.out_ready = (bp == 0);
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    b4.a = $urandom;
    b4.b = $urandom;
    b4.sub = ~sub;
    b4.cin = ~cin;
    chk("in_ready_busy", b4.in_ready, 0);
    lat = 0;
    while (!b4.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("sum", b4.sum, es);
    chk("cout", b4.cout, eco);
    chk("ovf", b4.ovf, eov);
    chk("zero", b4.zero, ez);
    for (int k = 0; k < bp; k++) begin
      if (k == 0) begin
        b4.a = 32'd1;
        b4.b = 32'd1;
        b4.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      b4.in_valid = 1'b0;
      chk("bp_valid", b4.out_valid, 1);
      chk("bp_in_ready", b4.in_ready, 0);
      chk("bp_sum", b4.sum, es);
      chk("bp_flags", {b4.cout, b4.ovf, b4.zero}, {eco, eov, ez});
    end
    b4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_valid", b4.out_valid, 0);
    chk("post_in_ready", b4.in_ready, 1);
  endtask

  task automatic do_op1(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic sub,
                        input logic cin);
    logic [31:0] es;
    logic eco, eov, ez;
    int lat;
    model(8, {24'd0, a}, {24'd0, b}, sub, cin, es, eco, eov, ez);
    @(negedge clk);
    chk("n1_in_ready", b1.in_ready, 1);
    b1.a = a;
    b1.b = b;
    b1.sub = sub;
    b1.cin = cin;
    b1.in_valid = 1'b1;
    b1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    lat = 0;
    while (!b1.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("n1_latency", lat, 1);
    chk("n1_sum", b1.sum, es[7:0]);
    chk("n1_flags", {b1.cout, b1.ovf, b1.zero}, {eco, eov, ez});
    @(posedge clk);
    #1;
    chk("n1_post_valid", b1.out_valid, 0);
  endtask

  initial begin
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    b4.a = '0;
    b4.b = '0;
    b4.sub = 1'b0;
    b4.cin = 1'b0;
    b1.in_valid = 1'b0;
    b1.out_ready = 1'b1;
    b1.a = '0;
    b1.b = '0;
    b1.sub = 1'b0;
    b1.cin = 1'b0;

    #12;
    chk("rst_in_ready", b4.in_ready, 0);
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_sum", b4.sum, 0);
    chk("rst_flags", {b4.cout, b4.ovf, b4.zero}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", b4.in_ready, 1);

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 3);

    // Abort an operation after two RUN cycles.
    @(negedge clk);
    b4.a = 32'h1111_1111;
    b4.b = 32'h2222_2222;
    b4.sub = 1'b0;
    b4.cin = 1'b0;
    b4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("partial_sum", b4.sum, 32'h0000_3333);
    rst = 1'b1;
    #1;
    chk("arst_sum", b4.sum, 0);
    chk("arst_valid", b4.out_valid, 0);
    chk("arst_in_ready", b4.in_ready, 0);
    chk("arst_flags", {b4.cout, b4.ovf, b4.zero}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arel_in_ready", b4.in_ready, 1);
    do_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      do_op($urandom, $urandom, 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)));
    end

    do_op1(8'h80, 8'h80, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      do_op1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
